// File: rtl/dmem_lsu_arbiter.sv
// dmem_lsu_arbiter: round-robin arbiter between core LSU and debug loader in front of a word memory,
// splitting byte-addressed RV32I loads/stores into one or two lane-aligned word cycles.
module dmem_lsu_arbiter #(
    parameter int ADDR_W           = 17,
    parameter bit ALLOW_MISALIGNED = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              c_req_valid,
    output logic              c_req_ready,
    input  logic              c_req_we,
    input  logic [2:0]        c_req_funct3,
    input  logic [ADDR_W-1:0] c_req_addr,
    input  logic [31:0]       c_req_wdata,
    output logic              c_rsp_valid,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [2:0]        d_req_funct3,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [31:0]       d_req_wdata,
    output logic              d_rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    typedef enum logic [2:0] {IDLE, A0, A1, WAIT, ERR} state_t;
    state_t            state;
    logic              last_d, port_d, r_we, r_split;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata, lo_word;
    logic              gnt_d, hs, s_we, s_split, s_bad;
    logic [2:0]        s_f3;
    logic [ADDR_W-1:0] s_addr;
    logic [31:0]       s_wdata;
    logic [1:0]        off;
    logic [3:0]        mask;
    logic [ADDR_W-3:0] word;
    logic [63:0]       rd_cat;
    logic [31:0]       rd_sh, rd_ext;
    // on a tie the port not granted last wins; last_d resets to 1 so the core wins first
    assign gnt_d       = d_req_valid & (~c_req_valid | ~last_d);
    assign c_req_ready = (state == IDLE) & c_req_valid & ~gnt_d;
    assign d_req_ready = (state == IDLE) & gnt_d;
    assign hs          = c_req_ready | d_req_ready;
    assign s_we        = gnt_d ? d_req_we : c_req_we;
    assign s_f3        = gnt_d ? d_req_funct3 : c_req_funct3;
    assign s_addr      = gnt_d ? d_req_addr : c_req_addr;
    assign s_wdata     = gnt_d ? d_req_wdata : c_req_wdata;
    assign s_split     = (s_f3[1:0] == 2'b10 && s_addr[1:0] != 2'b00) ||
                         (s_f3[1:0] == 2'b01 && s_addr[1:0] == 2'b11);
    assign s_bad       = s_f3 == 3'b011 || s_f3[2:1] == 2'b11 || (s_we && s_f3[2]) ||
                         (s_split && !ALLOW_MISALIGNED);
    assign off         = r_addr[1:0];
    assign word        = r_addr[ADDR_W-1:2];
    assign mask        = r_f3[1:0] == 2'b00 ? 4'b0001 : r_f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111;
    assign mem_en      = state == A0 || state == A1;
    assign mem_addr    = state == A1 ? word + {{(ADDR_W-3){1'b0}}, 1'b1} : word;
    assign mem_we      = (mem_en && r_we) ? (state == A1 ? mask >> (3'd4 - {1'b0, off}) : mask << off) : 4'b0000;
    assign mem_wdata   = state == A1 ? r_wdata >> {3'd4 - {1'b0, off}, 3'b000} : r_wdata << {off, 3'b000};
    // split reads place word 1 above word 0 so one byte-offset select covers both cases
    assign rd_cat      = r_split ? {mem_rdata, lo_word} : {32'h0, mem_rdata};
    assign rd_sh       = rd_cat[{off, 3'b000} +: 32];
    assign rd_ext      = r_f3[1:0] == 2'b00 ? {{24{~r_f3[2] & rd_sh[7]}}, rd_sh[7:0]} :
                         r_f3[1:0] == 2'b01 ? {{16{~r_f3[2] & rd_sh[15]}}, rd_sh[15:0]} : rd_sh;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            last_d      <= 1'b1;
            port_d      <= 1'b0;
            r_we        <= 1'b0;
            r_split     <= 1'b0;
            r_f3        <= 3'b000;
            r_addr      <= '0;
            r_wdata     <= 32'h0;
            lo_word     <= 32'h0;
            c_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            rsp_rdata   <= 32'h0;
            rsp_err     <= 1'b0;
        end else begin
            c_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            case (state)
                IDLE: if (hs) begin
                    port_d  <= gnt_d;
                    last_d  <= gnt_d;
                    r_we    <= s_we;
                    r_f3    <= s_f3;
                    r_addr  <= s_addr;
                    r_wdata <= s_wdata;
                    r_split <= s_split;
                    state   <= s_bad ? ERR : A0;
                end
                A0: state <= r_split ? A1 : WAIT;
                A1: begin
                    lo_word <= mem_rdata;
                    state   <= WAIT;
                end
                WAIT, ERR: begin
                    rsp_rdata   <= (state == WAIT && !r_we) ? rd_ext : 32'h0;
                    rsp_err     <= state == ERR;
                    c_rsp_valid <= !port_d;
                    d_rsp_valid <= port_d;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu_arbiter.sv
// tb_dmem_lsu_arbiter: vector table, arbitration, reset and random checks against a byte-array model.
module tb_dmem_lsu_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        c_req_valid = 0, c_req_we = 0, c_req_ready, c_rsp_valid;
    logic [2:0]  c_req_funct3 = 0;
    logic [16:0] c_req_addr = 0;
    logic [31:0] c_req_wdata = 0;
    logic        d_req_valid = 0, d_req_we = 0, d_req_ready, d_rsp_valid;
    logic [2:0]  d_req_funct3 = 0;
    logic [16:0] d_req_addr = 0;
    logic [31:0] d_req_wdata = 0;
    logic [31:0] rsp_rdata, mem_wdata, mem_rdata;
    logic        rsp_err, mem_en;
    logic [3:0]  mem_we;
    logic [14:0] mem_addr;

    logic        e_c_req_valid = 0, e_c_req_we = 0, e_c_req_ready, e_c_rsp_valid, e_d_req_ready, e_d_rsp_valid;
    logic [2:0]  e_c_req_funct3 = 0;
    logic [16:0] e_c_req_addr = 0;
    logic [31:0] e_c_req_wdata = 0, e_rsp_rdata, e_mem_wdata;
    logic        e_rsp_err, e_mem_en;
    logic [3:0]  e_mem_we;
    logic [14:0] e_mem_addr;

    int checks = 0, errors = 0, e_mem_cnt = 0;

    dmem_lsu_arbiter #(.ADDR_W(17), .ALLOW_MISALIGNED(1'b1)) u0 (
        .clk(clk), .rst(rst),
        .c_req_valid(c_req_valid), .c_req_ready(c_req_ready), .c_req_we(c_req_we),
        .c_req_funct3(c_req_funct3), .c_req_addr(c_req_addr), .c_req_wdata(c_req_wdata), .c_rsp_valid(c_rsp_valid),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_funct3(d_req_funct3), .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata), .d_rsp_valid(d_rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    dmem_lsu_arbiter #(.ADDR_W(17), .ALLOW_MISALIGNED(1'b0)) u1 (
        .clk(clk), .rst(rst),
        .c_req_valid(e_c_req_valid), .c_req_ready(e_c_req_ready), .c_req_we(e_c_req_we),
        .c_req_funct3(e_c_req_funct3), .c_req_addr(e_c_req_addr), .c_req_wdata(e_c_req_wdata), .c_rsp_valid(e_c_rsp_valid),
        .d_req_valid(1'b0), .d_req_ready(e_d_req_ready), .d_req_we(1'b0),
        .d_req_funct3(3'b000), .d_req_addr(17'h0), .d_req_wdata(32'h0), .d_rsp_valid(e_d_rsp_valid),
        .rsp_rdata(e_rsp_rdata), .rsp_err(e_rsp_err),
        .mem_en(e_mem_en), .mem_we(e_mem_we), .mem_addr(e_mem_addr), .mem_wdata(e_mem_wdata), .mem_rdata(32'h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // word memory seen by the DUT: byte-lane writes, registered read data
    logic [31:0] mem [0:32767];
    always @(posedge clk) if (mem_en) begin
        for (int i = 0; i < 4; i++) if (mem_we[i]) mem[mem_addr][8*i +: 8] = mem_wdata[8*i +: 8];
        if (mem_we == 4'b0000) mem_rdata <= mem[mem_addr];
    end

    typedef struct {logic [14:0] a; logic [3:0] we; logic [31:0] wd;} mcyc_t;
    mcyc_t log_q[$];
    always @(negedge clk) begin
        if (mem_en) log_q.push_back('{mem_addr, mem_we, mem_wdata});
        else chk("mem_we_idle", 32'(mem_we), 32'h0);
        if (e_mem_en) e_mem_cnt++;
        chk("e_d_rsp_idle", 32'({e_d_req_ready, e_d_rsp_valid}), 32'h0);
    end

    // reference: flat byte array, accesses wrap modulo the byte address space
    logic [7:0] ref_b [0:131071];
    function automatic int size_of(input logic [2:0] f3);
        return f3[1:0] == 2'b00 ? 1 : f3[1:0] == 2'b01 ? 2 : 4;
    endfunction
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [16:0] a);
        logic [31:0] v = 32'h0;
        int n = size_of(f3);
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_b[17'(a + 17'(i))];
        if (!f3[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
        if (!f3[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
        return v;
    endfunction
    function automatic void model_store(input logic [2:0] f3, input logic [16:0] a, input logic [31:0] wd);
        for (int i = 0; i < size_of(f3); i++) ref_b[17'(a + 17'(i))] = wd[8*i +: 8];
    endfunction

    task automatic run_req(input bit p, input bit we, input logic [2:0] f3, input logic [16:0] a,
                           input logic [31:0] wd, output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        if (p) begin
            d_req_valid = 1; d_req_we = we; d_req_funct3 = f3; d_req_addr = a; d_req_wdata = wd;
        end else begin
            c_req_valid = 1; c_req_we = we; c_req_funct3 = f3; c_req_addr = a; c_req_wdata = wd;
        end
        #1;
        n = 0;
        while (!(p ? d_req_ready : c_req_ready) && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("req_ready_in_time", 32'(n < 20), 32'h1);
        log_q.delete();
        @(posedge clk);
        #1;
        c_req_valid = 0;
        d_req_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(c_rsp_valid || d_rsp_valid) && lat < 10);
        chk("rsp_port", 32'({c_rsp_valid, d_rsp_valid}), p ? 32'h1 : 32'h2);
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        chk("rsp_one_cycle", 32'(c_rsp_valid | d_rsp_valid), 32'h0);
    endtask

    task automatic e_req(input bit we, input logic [2:0] f3, input logic [16:0] a,
                         output logic [31:0] rd, output logic er, output int lat, output int mc);
        int n;
        @(negedge clk);
        e_c_req_valid = 1; e_c_req_we = we; e_c_req_funct3 = f3; e_c_req_addr = a; e_c_req_wdata = 32'h5A5A5A5A;
        #1;
        n = 0;
        while (!e_c_req_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        e_mem_cnt = 0;
        @(posedge clk);
        #1;
        e_c_req_valid = 0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!e_c_rsp_valid && lat < 10);
        rd = e_rsp_rdata;
        er = e_rsp_err;
        mc = e_mem_cnt;
    endtask

    typedef struct {
        bit p; bit we; logic [2:0] f3; logic [16:0] a; logic [31:0] wd;
        logic [31:0] rd; bit er; int lat;
        bit cm; logic [14:0] a0; logic [3:0] we0; logic [31:0] wd0; logic [14:0] a1; logic [3:0] we1; logic [31:0] wd1;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic er;
        int lat, mc, exp_g, ngr, last_cyc, nrsp;
        bit stop;
        int gq[$];
        for (int i = 0; i < 32768; i++) mem[i] = 32'h0;
        for (int i = 0; i < 131072; i++) ref_b[i] = 8'h0;
        mem_rdata = 32'h0;

        #12;
        chk("rst_ready", 32'({c_req_ready, d_req_ready, e_c_req_ready}), 32'h0);
        chk("rst_rsp_valid", 32'({c_rsp_valid, d_rsp_valid, e_c_rsp_valid}), 32'h0);
        chk("rst_mem_en", 32'({mem_en, e_mem_en}), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        chk("rst_err", 32'(rsp_err), 32'h0);
        @(negedge clk);
        rst = 0;

        tbl.push_back('{0,1,3'b010,17'h100,32'h12345678, 32'h0,0,3, 1,15'h40,4'hF,32'h12345678,15'h0,4'h0,32'h0});
        tbl.push_back('{0,0,3'b000,17'h101,32'h0, 32'h56,0,3, 1,15'h40,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{1,0,3'b001,17'h102,32'h0, 32'h1234,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,1,3'b000,17'h203,32'h80, 32'h0,0,3, 1,15'h80,4'h8,32'h80000000,15'h0,4'h0,32'h0});
        tbl.push_back('{1,0,3'b000,17'h203,32'h0, 32'hFFFFFF80,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,0,3'b100,17'h203,32'h0, 32'h80,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,1,3'b010,17'h302,32'hAABBCCDD, 32'h0,0,4, 1,15'hC0,4'hC,32'hCCDD0000,15'hC1,4'h3,32'h0000AABB});
        tbl.push_back('{1,0,3'b010,17'h302,32'h0, 32'hAABBCCDD,0,4, 1,15'hC0,4'h0,32'h0,15'hC1,4'h0,32'h0});
        tbl.push_back('{0,1,3'b010,17'h1FFFE,32'h11223344, 32'h0,0,4, 1,15'h7FFF,4'hC,32'h33440000,15'h0,4'h3,32'h00001122});
        tbl.push_back('{0,0,3'b010,17'h1FFFE,32'h0, 32'h11223344,0,4, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{1,0,3'b001,17'h1FFFF,32'h0, 32'h2233,0,4, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{1,0,3'b101,17'h1FFFF,32'h0, 32'h2233,0,4, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,0,3'b000,17'h1FFFF,32'h0, 32'h33,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,1,3'b001,17'h400,32'h0000BEEF, 32'h0,0,3, 1,15'h100,4'h3,32'h0000BEEF,15'h0,4'h0,32'h0});
        tbl.push_back('{0,0,3'b001,17'h400,32'h0, 32'hFFFFBEEF,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{1,0,3'b101,17'h400,32'h0, 32'h0000BEEF,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,1,3'b001,17'h403,32'h0000CAFE, 32'h0,0,4, 1,15'h100,4'h8,32'hFE000000,15'h101,4'h1,32'h000000CA});
        tbl.push_back('{1,0,3'b101,17'h403,32'h0, 32'h0000CAFE,0,4, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,0,3'b001,17'h403,32'h0, 32'hFFFFCAFE,0,4, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{1,0,3'b010,17'h400,32'h0, 32'hFE00BEEF,0,3, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,0,3'b011,17'h0,32'h0, 32'h0,1,2, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{1,1,3'b101,17'h0,32'hFFFF, 32'h0,1,2, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});
        tbl.push_back('{0,1,3'b110,17'h10,32'h0, 32'h0,1,2, 0,15'h0,4'h0,32'h0,15'h0,4'h0,32'h0});

        foreach (tbl[k]) begin
            run_req(tbl[k].p, tbl[k].we, tbl[k].f3, tbl[k].a, tbl[k].wd, rd, er, lat);
            chk($sformatf("vec%0d_rdata", k), rd, tbl[k].rd);
            chk($sformatf("vec%0d_err", k), 32'(er), 32'(tbl[k].er));
            chk($sformatf("vec%0d_latency", k), lat, tbl[k].lat);
            chk($sformatf("vec%0d_mem_cycles", k), log_q.size(), tbl[k].lat - 2);
            if (tbl[k].cm) begin
                chk($sformatf("vec%0d_a0_addr", k), 32'(log_q[0].a), 32'(tbl[k].a0));
                chk($sformatf("vec%0d_a0_we", k), 32'(log_q[0].we), 32'(tbl[k].we0));
                if (tbl[k].we0 != 4'h0) chk($sformatf("vec%0d_a0_wdata", k), log_q[0].wd, tbl[k].wd0);
                if (tbl[k].lat == 4) begin
                    chk($sformatf("vec%0d_a1_addr", k), 32'(log_q[1].a), 32'(tbl[k].a1));
                    chk($sformatf("vec%0d_a1_we", k), 32'(log_q[1].we), 32'(tbl[k].we1));
                    if (tbl[k].we1 != 4'h0) chk($sformatf("vec%0d_a1_wdata", k), log_q[1].wd, tbl[k].wd1);
                end
            end
            if (tbl[k].we && !tbl[k].er) model_store(tbl[k].f3, tbl[k].a, tbl[k].wd);
        end

        // arbitration: both ports hammer aligned LW from reset; grants must alternate c,d,c,d every 3 cycles
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        c_req_valid = 1; c_req_we = 0; c_req_funct3 = 3'b010; c_req_addr = 17'h100;
        d_req_valid = 1; d_req_we = 0; d_req_funct3 = 3'b010; d_req_addr = 17'h300;
        exp_g = 0; ngr = 0; last_cyc = -1; stop = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (c_rsp_valid || d_rsp_valid) begin
                int g;
                g = gq.size() > 0 ? gq.pop_front() : -1;
                chk("arb_rsp_port", 32'({c_rsp_valid, d_rsp_valid}), g == 1 ? 32'h1 : 32'h2);
                chk("arb_rdata", rsp_rdata, model_load(3'b010, g == 1 ? 17'h300 : 17'h100));
            end
            if (c_req_ready || d_req_ready) begin
                chk("arb_grant", 32'({c_req_ready, d_req_ready}), exp_g == 1 ? 32'h1 : 32'h2);
                if (last_cyc >= 0) chk("arb_gap", cyc - last_cyc, 3);
                gq.push_back(d_req_ready ? 1 : 0);
                exp_g ^= 1;
                ngr++;
                last_cyc = cyc;
            end else if (cyc >= 30 && !stop) begin
                c_req_valid = 0;
                d_req_valid = 0;
                stop = 1;
            end
            @(negedge clk);
        end
        chk("arb_grant_count", ngr, 11);
        chk("arb_drained", gq.size(), 0);

        // reset while the second half of a split store is on the bus
        @(negedge clk);
        c_req_valid = 1; c_req_we = 1; c_req_funct3 = 3'b010; c_req_addr = 17'h602; c_req_wdata = 32'hDEADBEEF;
        #1;
        chk("rstmid_ready", 32'(c_req_ready), 32'h1);
        @(posedge clk);
        #1;
        c_req_valid = 0;
        @(posedge clk);
        #1;
        chk("rstmid_a1_en", 32'(mem_en), 32'h1);
        chk("rstmid_a1_addr", 32'(mem_addr), 32'h181);
        chk("rstmid_a1_we", 32'(mem_we), 32'h3);
        rst = 1;
        #1;
        chk("rstmid_en_drop", 32'(mem_en), 32'h0);
        chk("rstmid_we_drop", 32'(mem_we), 32'h0);
        @(negedge clk);
        rst = 0;
        nrsp = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (c_rsp_valid || d_rsp_valid || mem_en) nrsp++;
        end
        chk("rstmid_no_rsp", nrsp, 0);
        ref_b[17'h602] = 8'hEF;
        ref_b[17'h603] = 8'hBE;
        run_req(0, 0, 3'b010, 17'h600, 32'h0, rd, er, lat);
        chk("rstmid_lw600", rd, 32'hBEEF0000);
        chk("rstmid_lw600_lat", lat, 3);
        run_req(0, 0, 3'b010, 17'h604, 32'h0, rd, er, lat);
        chk("rstmid_lw604", rd, 32'h0);

        // randomized traffic against the byte-array model
        for (int t = 0; t < 200; t++) begin
            bit p, we, e, sp;
            logic [2:0] f3;
            logic [16:0] a;
            logic [31:0] wd, exp_rd;
            int n;
            p = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a = $urandom_range(0, 1) ? 17'h500 + 17'($urandom_range(0, 63)) : 17'h1FFF0 + 17'($urandom_range(0, 15));
            wd = $urandom;
            n = size_of(f3);
            e = f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111 || (we && f3[2]);
            sp = !e && ((a >> 2) != (17'(a + 17'(n - 1)) >> 2));
            exp_rd = (e || we) ? 32'h0 : model_load(f3, a);
            run_req(p, we, f3, a, wd, rd, er, lat);
            chk($sformatf("rnd%0d_rdata", t), rd, exp_rd);
            chk($sformatf("rnd%0d_err", t), 32'(er), 32'(e));
            chk($sformatf("rnd%0d_latency", t), lat, e ? 2 : sp ? 4 : 3);
            chk($sformatf("rnd%0d_mem_cycles", t), log_q.size(), e ? 0 : sp ? 2 : 1);
            if (we && !e) model_store(f3, a, wd);
        end

        // instance without misaligned support rejects word-crossing accesses
        e_req(1, 3'b010, 17'h301, rd, er, lat, mc);
        chk("nomis_sw301_err", 32'(er), 32'h1);
        chk("nomis_sw301_rdata", rd, 32'h0);
        chk("nomis_sw301_lat", lat, 2);
        chk("nomis_sw301_mem", mc, 0);
        e_req(0, 3'b001, 17'h303, rd, er, lat, mc);
        chk("nomis_lh303_err", 32'(er), 32'h1);
        chk("nomis_lh303_mem", mc, 0);
        e_req(0, 3'b010, 17'h300, rd, er, lat, mc);
        chk("nomis_lw300_err", 32'(er), 32'h0);
        chk("nomis_lw300_lat", lat, 3);
        chk("nomis_lw300_mem", mc, 1);
        e_req(0, 3'b001, 17'h302, rd, er, lat, mc);
        chk("nomis_lh302_err", 32'(er), 32'h0);
        chk("nomis_lh302_lat", lat, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
